// File: rtl/inst_fetcher_pkg.sv
// Shared core definitions: core phase encodings and fetcher state encodings.
package inst_fetcher_pkg;

   // Core phase values seen on core_state; anything else is a no-op here.
   localparam logic [2:0] CoreFetch  = 3'b001;
   localparam logic [2:0] CoreDecode = 3'b010;

   typedef enum logic [2:0] {
      StIdle     = 3'b000,
      StFetching = 3'b001,
      StFetched  = 3'b010
   } fetcher_state_e;

   localparam logic [15:0] MissCountMax = 16'hFFFF;

   // Saturating increment for the miss counter.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == MissCountMax) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Program-memory read channel: request (valid/address) and response (ready/data).
interface inst_fetcher_if #(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned DATA_BITS = 16
);
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;

   // Fetcher side issues requests.
   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   // Memory side answers them.
   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher with a one-entry last-instruction buffer in front of program memory.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
   parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             flush,
   inst_fetcher_if.master                   mem,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [15:0]                      miss_count
);

   fetcher_state_e                   state_q;
   logic                             valid_q;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
   logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
   logic [15:0]                      miss_q;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] tag_pc_q;
   logic                             tag_valid_q;
   logic [PROGRAM_MEM_DATA_BITS-1:0] tag_data_q;
   // Set when a flush lands while a read is in flight; its data must not be cached.
   logic                             uncacheable_q;
   logic                             hit;

   // A flush in the same cycle overrides a matching buffer entry.
   assign hit = tag_valid_q && (tag_pc_q == current_pc) && !flush;

   // Fetch FSM, request channel, buffer and miss counter, all registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         valid_q       <= 1'b0;
         addr_q        <= '0;
         instr_q       <= '0;
         miss_q        <= '0;
         tag_pc_q      <= '0;
         tag_valid_q   <= 1'b0;
         tag_data_q    <= '0;
         uncacheable_q <= 1'b0;
      end else begin
         if (flush) begin
            tag_valid_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (core_state == CoreFetch) begin
                  if (hit) begin
                     instr_q <= tag_data_q;
                     state_q <= StFetched;
                  end else begin
                     valid_q       <= 1'b1;
                     addr_q        <= current_pc;
                     uncacheable_q <= 1'b0;
                     miss_q        <= sat_inc(miss_q);
                     state_q       <= StFetching;
                  end
               end
            end
            StFetching: begin
               if (flush) begin
                  uncacheable_q <= 1'b1;
               end
               if (mem.mem_read_ready) begin
                  instr_q <= mem.mem_read_data;
                  valid_q <= 1'b0;
                  state_q <= StFetched;
                  if (!uncacheable_q && !flush) begin
                     tag_pc_q    <= addr_q;
                     tag_data_q  <= mem.mem_read_data;
                     tag_valid_q <= 1'b1;
                  end
               end
            end
            StFetched: begin
               if (core_state == CoreDecode) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem.mem_read_valid   = valid_q;
   assign mem.mem_read_address = addr_q;
   assign fetcher_state        = state_q;
   assign instruction          = instr_q;
   assign miss_count           = miss_q;

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8: program address width.
REQ-002 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16: instruction width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port core_state, input, 3: core phase; FETCH=3'b001, DECODE=3'b010, all other values are no-ops for this block.
REQ-006 SHALL have port current_pc, input, PROGRAM_MEM_ADDR_BITS: address to fetch, driven by the PC block.
REQ-007 SHALL have port flush, input, 1: invalidates the last-instruction buffer.
REQ-008 SHALL have port mem_read_valid, output, 1: program-memory read request.
REQ-009 SHALL have port mem_read_address, output, PROGRAM_MEM_ADDR_BITS: request address.
REQ-010 SHALL have port mem_read_ready, input, 1: response strobe; data valid on this cycle.
REQ-011 SHALL have port mem_read_data, input, PROGRAM_MEM_DATA_BITS: response data.
REQ-012 SHALL have port fetcher_state, output, 3: IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-013 SHALL have port instruction, output, PROGRAM_MEM_DATA_BITS: fetched instruction, stable while FETCHED.
REQ-014 SHALL have port miss_count, output, 16: number of memory reads issued since reset.

Function
REQ-015 SHALL hold a one-entry buffer: tag_pc, tag_valid, tag_data.
REQ-016 In IDLE with core_state==FETCH and tag_valid==1, tag_pc==current_pc, flush==0 (hit) SHALL load instruction<=tag_data, go FETCHED next cycle; no memory request.
REQ-017 In IDLE with core_state==FETCH and no hit SHALL register mem_read_valid<=1, mem_read_address<=current_pc, increment miss_count, go FETCHING.
REQ-018 In FETCHING SHALL hold mem_read_valid and mem_read_address constant until mem_read_ready==1.
REQ-019 On mem_read_ready==1 in FETCHING SHALL register instruction<=mem_read_data, mem_read_valid<=0, go FETCHED; tag_pc/tag_data updated and tag_valid<=1 unless the request is marked uncacheable (REQ-023).
REQ-020 mem_read_ready SHALL be ignored outside FETCHING.
REQ-021 In FETCHED SHALL return to IDLE when core_state==DECODE; instruction SHALL hold its value until the next fetch completes.
REQ-022 flush SHALL clear tag_valid on the next edge in any state; flush simultaneous with a would-be hit SHALL be treated as a miss.
REQ-023 flush during FETCHING SHALL mark the in-flight request uncacheable: response still delivered to instruction, tag_valid stays 0.
REQ-024 miss_count SHALL saturate at 16'hFFFF.
REQ-025 Fetch-to-FETCHED latency: 1 cycle on hit; 1 + cycles-until-ready on miss (minimum 2).
REQ-026 core_state changes while FETCHING SHALL NOT abort the request.

Reset
REQ-027 With reset==0 at a rising edge SHALL set fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, miss_count=0, tag_valid=0, tag_pc=0, tag_data=0, uncacheable flag=0.
REQ-028 Reset mid-FETCHING SHALL drop mem_read_valid at that edge; a later mem_read_ready SHALL be ignored.

Structure
REQ-029 Fetcher state encodings and core_state encodings SHALL live in the shared core package.
REQ-030 SHALL be a single module; no sub-modules.

Verification
REQ-031 Miss: reset, current_pc=8'h05, core_state=FETCH, ready after 3 cycles with data 16'h1234 -> valid high 3 cycles, address 8'h05, instruction=16'h1234, FETCHED, miss_count=1.
REQ-032 Hit: repeat fetch of 8'h05 after DECODE -> FETCHED next cycle, mem_read_valid never asserted, instruction=16'h1234, miss_count=1.
REQ-033 Flush+hit: fetch 8'h05 with flush=1 same cycle -> memory read issued, miss_count=2.
REQ-034 Flush in flight: miss on 8'h07, flush during FETCHING, data 16'hBEEF -> instruction=16'hBEEF; refetch 8'h07 misses.
REQ-035 Reset mid-fetch: reset low while FETCHING -> valid=0, state IDLE, following ready pulse ignored, instruction=0.
REQ-036 Stray ready: mem_read_ready=1 in IDLE with data 16'hFFFF -> instruction, state, and tag buffer unchanged.
